instr_reg_stim_driver: RTL and testbench

- Synthesizable, parametrised stimulus driver for the instruction-register DUT family.
- Accepts instruction transactions on a valid/ready port and buffers them in a FIFO.
- Drives them onto the DUT control pins one per cycle, with an optional programmable idle gap between them.
- Generates a timed DUT reset sequence after its own reset and on request. Used in emulation/FPGA benches where a procedural driver task cannot run.

---
 rtl/instr_reg_stim_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_instr_reg_stim_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_stim_driver.sv
// ----------------------------------------------------------------------------
// instr_reg_stim_driver
//
// Stimulus driver for the instruction-register DUT family, for emulation or
// FPGA benches where a procedural driver task cannot run. Instruction
// transactions are accepted on a valid/ready port and buffered in a FIFO.
// They are then driven onto the DUT control pins one per cycle, optionally
// separated by a programmable number of idle cycles. A timed DUT reset
// sequence is generated after the driver's own reset and whenever
// start_reset is requested.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   s_valid / s_ready   transaction handshake (s_ready = FIFO not full)
//   s_*                 transaction fields: reset_n, load_en, write/read
//                       pointers, operands A/B, opcode
//   gap_cycles          idle cycles inserted after each driven transaction
//   start_reset         request a DUT reset sequence
//   dut_*               registered drive onto the DUT pins
//   busy                FSM not idle or FIFO not empty
//   fifo_level          current FIFO occupancy
//   sent_count          number of transactions driven (wraps)
// ----------------------------------------------------------------------------
module instr_reg_stim_driver #(
   parameter int NUM_REGS   = 32,
   parameter int OPERAND_W  = 32,
   parameter int OPCODE_W   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_W      = 4,
   parameter int RST_CYCLES = 2,
   localparam int PTR_W     = $clog2(NUM_REGS),
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_reset_n,
   input  logic                 s_load_en,
   input  logic [PTR_W-1:0]     s_write_pointer,
   input  logic [PTR_W-1:0]     s_read_pointer,
   input  logic [OPERAND_W-1:0] s_operand_a,
   input  logic [OPERAND_W-1:0] s_operand_b,
   input  logic [OPCODE_W-1:0]  s_opcode,
   input  logic [GAP_W-1:0]     gap_cycles,
   input  logic                 start_reset,
   output logic                 dut_reset_n,
   output logic                 dut_load_en,
   output logic [PTR_W-1:0]     dut_write_pointer,
   output logic [PTR_W-1:0]     dut_read_pointer,
   output logic [OPERAND_W-1:0] dut_operand_a,
   output logic [OPERAND_W-1:0] dut_operand_b,
   output logic [OPCODE_W-1:0]  dut_opcode,
   output logic                 busy,
   output logic [LVL_W-1:0]     fifo_level,
   output logic [15:0]          sent_count
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int RST_W = $clog2(RST_CYCLES + 1);

   typedef struct packed {
      logic                 reset_n;
      logic                 load_en;
      logic [PTR_W-1:0]     wptr;
      logic [PTR_W-1:0]     rptr;
      logic [OPERAND_W-1:0] opa;
      logic [OPERAND_W-1:0] opb;
      logic [OPCODE_W-1:0]  opcode;
   } entry_t;

   typedef enum logic [1:0] {RST_SEQ, IDLE, DRIVE, GAP} state_e;

   // FIFO storage and control
   entry_t          mem [FIFO_DEPTH];
   entry_t          s_entry;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q;
   logic            full, empty, push, pop;

   // Driver FSM state
   state_e          state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [15:0]     sent_q, sent_d;
   entry_t          out_q, out_d;
   logic            go_rst;

   always_comb begin
      s_entry         = '0;
      s_entry.reset_n = s_reset_n;
      s_entry.load_en = s_load_en;
      s_entry.wptr    = s_write_pointer;
      s_entry.rptr    = s_read_pointer;
      s_entry.opa     = s_operand_a;
      s_entry.opb     = s_operand_b;
      s_entry.opcode  = s_opcode;
   end

   assign full  = (count_q == LVL_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   // s_ready depends only on the registered level, so a pop in the same
   // cycle never lets a push into a full FIFO.
   assign push  = s_valid && !full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= s_entry;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + LVL_W'(1);
            2'b01:   count_q <= count_q - LVL_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Next-state logic. go_rst and pop are decided per state, then applied
   // once below so every path that starts a sequence or pops behaves alike.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sent_d    = sent_q;
      out_d     = out_q;
      go_rst    = 1'b0;
      pop       = 1'b0;

      case (state_q)
         RST_SEQ: begin
            out_d.reset_n = 1'b0;
            out_d.load_en = 1'b0;
            rst_cnt_d     = rst_cnt_q - RST_W'(1);
            if (rst_cnt_q <= RST_W'(1)) begin
               state_d       = IDLE;
               out_d.reset_n = 1'b1;
            end
         end
         IDLE: begin
            out_d.load_en = 1'b0;
            out_d.reset_n = 1'b1;
            if (start_reset) go_rst = 1'b1;
            else if (!empty) pop = 1'b1;
         end
         DRIVE: begin
            if (start_reset) begin
               go_rst = 1'b1;
            end else if (gap_cycles != '0) begin
               gap_cnt_d     = gap_cycles;
               out_d.load_en = 1'b0;
               out_d.reset_n = 1'b1;
               state_d       = GAP;
            end else if (!empty) begin
               pop = 1'b1;
            end else begin
               out_d.load_en = 1'b0;
               out_d.reset_n = 1'b1;
               state_d       = IDLE;
            end
         end
         GAP: begin
            out_d.load_en = 1'b0;
            gap_cnt_d     = gap_cnt_q - GAP_W'(1);
            if (start_reset) begin
               go_rst = 1'b1;
            end else if (gap_cnt_q <= GAP_W'(1)) begin
               if (!empty) pop = 1'b1;
               else        state_d = IDLE;
            end
         end
         default: state_d = RST_SEQ;
      endcase

      if (go_rst) begin
         state_d       = RST_SEQ;
         rst_cnt_d     = RST_W'(RST_CYCLES);
         out_d.reset_n = 1'b0;
         out_d.load_en = 1'b0;
      end else if (pop) begin
         out_d   = mem[rd_ptr_q];
         sent_d  = sent_q + 16'd1;
         state_d = DRIVE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RST_SEQ;
         rst_cnt_q <= RST_W'(RST_CYCLES);
         gap_cnt_q <= '0;
         sent_q    <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sent_q    <= sent_d;
         out_q     <= out_d;
      end
   end

   assign s_ready           = !full;
   assign busy              = (state_q != IDLE) || !empty;
   assign fifo_level        = count_q;
   assign sent_count        = sent_q;
   assign dut_reset_n       = out_q.reset_n;
   assign dut_load_en       = out_q.load_en;
   assign dut_write_pointer = out_q.wptr;
   assign dut_read_pointer  = out_q.rptr;
   assign dut_operand_a     = out_q.opa;
   assign dut_operand_b     = out_q.opb;
   assign dut_opcode        = out_q.opcode;

endmodule

// File: tb/tb_instr_reg_stim_driver.sv
// ----------------------------------------------------------------------------
// Testbench for instr_reg_stim_driver. Transactions pushed by the stimulus
// thread are queued as expected DUT drives; a monitor pops the queue on
// every cycle where dut_load_en is high and compares fields, sent_count and
// the number of idle cycles since the previous drive.
// ----------------------------------------------------------------------------
module tb_instr_reg_stim_driver;
   localparam int PTR_W = 5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        s_valid, s_ready, s_reset_n, s_load_en;
   logic [4:0]  s_write_pointer, s_read_pointer;
   logic [31:0] s_operand_a, s_operand_b;
   logic [3:0]  s_opcode;
   logic [3:0]  gap_cycles;
   logic        start_reset;
   logic        dut_reset_n, dut_load_en;
   logic [4:0]  dut_write_pointer, dut_read_pointer;
   logic [31:0] dut_operand_a, dut_operand_b;
   logic [3:0]  dut_opcode;
   logic        busy;
   logic [3:0]  fifo_level;
   logic [15:0] sent_count;

   always #5 clk = ~clk;

   instr_reg_stim_driver dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_reset_n         (s_reset_n),
      .s_load_en         (s_load_en),
      .s_write_pointer   (s_write_pointer),
      .s_read_pointer    (s_read_pointer),
      .s_operand_a       (s_operand_a),
      .s_operand_b       (s_operand_b),
      .s_opcode          (s_opcode),
      .gap_cycles        (gap_cycles),
      .start_reset       (start_reset),
      .dut_reset_n       (dut_reset_n),
      .dut_load_en       (dut_load_en),
      .dut_write_pointer (dut_write_pointer),
      .dut_read_pointer  (dut_read_pointer),
      .dut_operand_a     (dut_operand_a),
      .dut_operand_b     (dut_operand_b),
      .dut_opcode        (dut_opcode),
      .busy              (busy),
      .fifo_level        (fifo_level),
      .sent_count        (sent_count)
   );

   typedef struct {
      logic        rn;
      logic [3:0]  op;
      logic [4:0]  wp;
      logic [4:0]  rp;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] sent;
      int          gap;   // expected idle cycles before this drive, -1 = any
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          idle_run = 0;
   logic [15:0] tb_sent = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic rn, input logic [3:0] op, input logic [4:0] wp,
                       input logic [4:0] rp, input logic [31:0] a, input logic [31:0] b,
                       input int gap);
      exp_t e;
      int   n = 0;
      s_valid = 1'b1; s_reset_n = rn; s_load_en = 1'b1; s_opcode = op;
      s_write_pointer = wp; s_read_pointer = rp; s_operand_a = a; s_operand_b = b;
      while (!s_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout: s_ready stayed 0 for op %0d", op);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      tb_sent = tb_sent + 16'd1;
      e.rn = rn; e.op = op; e.wp = wp; e.rp = rp; e.a = a; e.b = b;
      e.sent = tb_sent; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int n = 0;
      while (!(busy == 1'b0 && exp_q.size() == 0) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= maxc) begin
         errors++;
         $display("FAIL %s: drain timeout, busy=%0b pending=%0d", name, busy, exp_q.size());
      end
   endtask

   task automatic wait_load(input logic [3:0] op, input int maxc, input string name);
      int n = 0;
      @(negedge clk);
      while (!(dut_load_en && dut_opcode == op) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= maxc) begin
         errors++;
         $display("FAIL %s: load of opcode %0d not seen", name, op);
      end
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            idle_run = 0;
         end else if (dut_load_en) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_load: got opcode %0d, expected no drive", dut_opcode);
            end else begin
               e = exp_q.pop_front();
               chk("drv_opcode",  32'(dut_opcode), 32'(e.op));
               chk("drv_wptr",    32'(dut_write_pointer), 32'(e.wp));
               chk("drv_rptr",    32'(dut_read_pointer), 32'(e.rp));
               chk("drv_opa",     dut_operand_a, e.a);
               chk("drv_opb",     dut_operand_b, e.b);
               chk("drv_reset_n", 32'(dut_reset_n), 32'(e.rn));
               chk("drv_sent",    32'(sent_count), 32'(e.sent));
               if (e.gap >= 0) chk("drv_gap", 32'(idle_run), 32'(e.gap));
            end
            idle_run = 0;
         end else begin
            idle_run++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; s_valid = 1'b0; s_reset_n = 1'b1; s_load_en = 1'b0;
      s_write_pointer = '0; s_read_pointer = '0; s_operand_a = '0; s_operand_b = '0;
      s_opcode = '0; gap_cycles = '0; start_reset = 1'b0;

      // reset state
      #12;
      chk("rst_dut_reset_n", 32'(dut_reset_n), 32'd0);
      chk("rst_load_en",     32'(dut_load_en), 32'd0);
      chk("rst_opcode",      32'(dut_opcode), 32'd0);
      chk("rst_opa",         dut_operand_a, 32'd0);
      chk("rst_sent",        32'(sent_count), 32'd0);
      chk("rst_level",       32'(fifo_level), 32'd0);
      chk("rst_s_ready",     32'(s_ready), 32'd1);
      chk("rst_busy",        32'(busy), 32'd1);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rstseq_low",      32'(dut_reset_n), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("rstseq_high",     32'(dut_reset_n), 32'd1);
      chk("rstseq_busy",     32'(busy), 32'd0);
      chk("rstseq_s_ready",  32'(s_ready), 32'd1);

      // back-to-back, no gap
      push(1'b1, 4'd1, 5'd0, 5'd3,  32'h0000_0011, 32'h0000_0022, -1);
      push(1'b1, 4'd2, 5'd1, 5'd4,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      push(1'b1, 4'd3, 5'd2, 5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      wait_idle(50, "b2b");
      chk("b2b_sent", 32'(sent_count), 32'd3);

      // gap of two idle cycles
      gap_cycles = 4'd2;
      push(1'b1, 4'd4, 5'd3, 5'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, -1);
      push(1'b1, 4'd5, 5'd4, 5'd1, 32'h0000_0001, 32'h0000_0002, 2);
      push(1'b1, 4'd6, 5'd5, 5'd2, 32'h0000_0003, 32'h0000_0004, 2);
      wait_idle(60, "gap2");
      chk("gap2_sent", 32'(sent_count), 32'd6);

      // fill the FIFO while the driver sits in a long gap
      gap_cycles = 4'd15;
      push(1'b1, 4'd7, 5'd6, 5'd7, 32'h0000_0070, 32'h0000_0071, -1);
      for (int i = 0; i < 8; i++)
         push(1'b1, 4'(8 + i), 5'(8 + i), 5'(16 + i), 32'h100 + 32'(i), 32'h200 + 32'(i), 15);
      chk("full_level",   32'(fifo_level), 32'd8);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b1; s_opcode = 4'd0; s_operand_a = 32'hDEAD_BEEF;
      @(posedge clk); @(posedge clk); #1;
      chk("ninth_rejected", 32'(fifo_level), 32'd8);
      s_valid = 1'b0;
      wait_idle(400, "fill");
      chk("fill_sent", 32'(sent_count), 32'd15);

      // start_reset during a DRIVE cycle with four entries queued
      push(1'b1, 4'd1, 5'd10, 5'd11, 32'h0000_1001, 32'h0000_2001, -1);
      push(1'b1, 4'd2, 5'd12, 5'd13, 32'h0000_1002, 32'h0000_2002, 15);
      push(1'b1, 4'd3, 5'd14, 5'd15, 32'h0000_1003, 32'h0000_2003, 3);
      push(1'b1, 4'd4, 5'd16, 5'd17, 32'h0000_1004, 32'h0000_2004, 0);
      push(1'b0, 4'd5, 5'd18, 5'd19, 32'h0000_1005, 32'h0000_2005, 0);
      push(1'b1, 4'd6, 5'd20, 5'd21, 32'h0000_1006, 32'h0000_2006, 0);
      wait_load(4'd2, 100, "sr_wait");
      chk("sr_queued", 32'(fifo_level), 32'd4);
      start_reset = 1'b1;
      @(posedge clk); #1;
      start_reset = 1'b0;
      gap_cycles  = 4'd0;
      @(negedge clk);
      chk("sr_low1",      32'(dut_reset_n), 32'd0);
      chk("sr_load_off",  32'(dut_load_en), 32'd0);
      chk("sr_level",     32'(fifo_level), 32'd4);
      chk("sr_sent_kept", 32'(sent_count), 32'd17);
      @(negedge clk);
      chk("sr_low2",      32'(dut_reset_n), 32'd0);
      @(negedge clk);
      chk("sr_release",   32'(dut_reset_n), 32'd1);
      wait_idle(100, "sr_drain");
      chk("sr_sent", 32'(sent_count), 32'd21);

      // asynchronous reset in the middle of a drain
      gap_cycles = 4'd3;
      push(1'b1, 4'd7,  5'd1, 5'd2, 32'h0000_3007, 32'h0000_4007, -1);
      push(1'b1, 4'd8,  5'd2, 5'd3, 32'h0000_3008, 32'h0000_4008, 3);
      push(1'b1, 4'd9,  5'd3, 5'd4, 32'h0000_3009, 32'h0000_4009, 3);
      push(1'b1, 4'd10, 5'd4, 5'd5, 32'h0000_300A, 32'h0000_400A, 3);
      wait_load(4'd8, 100, "ar_wait");
      #2 reset_n = 1'b0;
      #1;
      chk("ar_dut_reset_n", 32'(dut_reset_n), 32'd0);
      chk("ar_load_en",     32'(dut_load_en), 32'd0);
      chk("ar_opcode",      32'(dut_opcode), 32'd0);
      chk("ar_wptr",        32'(dut_write_pointer), 32'd0);
      chk("ar_rptr",        32'(dut_read_pointer), 32'd0);
      chk("ar_opa",         dut_operand_a, 32'd0);
      chk("ar_opb",         dut_operand_b, 32'd0);
      chk("ar_sent",        32'(sent_count), 32'd0);
      chk("ar_level",       32'(fifo_level), 32'd0);
      chk("ar_s_ready",     32'(s_ready), 32'd1);
      exp_q.delete();
      tb_sent = 16'd0;
      @(posedge clk); #1 reset_n = 1'b1;
      push(1'b1, 4'd12, 5'd9, 5'd8, 32'hCAFE_0001, 32'hCAFE_0002, -1);
      wait_idle(60, "ar_after");
      chk("ar_after_sent", 32'(sent_count), 32'd1);
      chk("pending_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
